// File: rtl/sensor_node_pkg.sv
// Shared state encoding and protocol constants for the sensor node responder.
package sensor_node_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_B2,
    LOOKUP,
    SEND_HDR,
    WAIT_HDR,
    SEND_VAL,
    WAIT_VAL
  } state_t;

  localparam logic [3:0] HDR_NIBBLE  = 4'h5;
  localparam logic [7:0] CMD_READ    = 8'h01;
  localparam logic [7:0] CMD_PEAK    = 8'h02;
  localparam logic [7:0] ERR_BYTE    = 8'hEE;
  localparam int         NUM_SENSORS = 16;

endpackage

// File: rtl/sensor_peak_bank.sv
// Per-sensor running maximum; a clear reloads one entry with its current live value.
module sensor_peak_bank
  import sensor_node_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [8*NUM_SENSORS-1:0] live,
  input  logic [3:0]               rd_idx,
  input  logic                     clr,
  output logic [7:0]               rd_peak
);

  logic [7:0] peak [NUM_SENSORS];

  // A clear wins over the max update so the reader sees the old peak this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SENSORS; i++) peak[i] <= 8'h00;
    end else begin
      for (int i = 0; i < NUM_SENSORS; i++) begin
        if (clr && rd_idx == 4'(i)) peak[i] <= live[8*i +: 8];
        else if (live[8*i +: 8] > peak[i]) peak[i] <= live[8*i +: 8];
      end
    end
  end

  assign rd_peak = peak[rd_idx];

endmodule

// File: rtl/sensor_node_responder.sv
// Two-byte UART request decoder returning a live or peak sensor value.
// Define SENSOR_NODE_RESP_ECHO_EN to echo the header byte ahead of the value.
module sensor_node_responder
  import sensor_node_pkg::*;
#(
  parameter int CLK_FREQ_HZ        = 25_000_000,
  parameter int REQ_TIMEOUT_CYCLES = CLK_FREQ_HZ / 1000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         rx_dv,
  input  logic [7:0]   rx_byte,
  input  logic         tx_active,
  input  logic         tx_done,
  output logic         tx_dv,
  output logic [7:0]   tx_byte,
  input  logic [127:0] sensor_bus,
  output logic [7:0]   drop_cnt
);

`ifdef SENSOR_NODE_RESP_ECHO_EN
  localparam bit ECHO = 1'b1;
`else
  localparam bit ECHO = 1'b0;
`endif

  localparam int               GAP_W    = $clog2(REQ_TIMEOUT_CYCLES + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(REQ_TIMEOUT_CYCLES - 1);

  state_t           state, state_nxt;
  logic [3:0]       idx;
  logic [7:0]       cmd;
  logic [7:0]       val_p1;
  logic [7:0]       live_val;
  logic [7:0]       peak_val;
  logic [7:0]       lookup_val;
  logic [GAP_W-1:0] gap_cnt;
  logic             drop_inc;
  logic             peak_clr;

  assign live_val = sensor_bus[{idx, 3'b000} +: 8];
  assign peak_clr = (state == LOOKUP) && (cmd == CMD_PEAK);

  sensor_peak_bank u_peak (
    .clk     (clk),
    .rst_n   (rst_n),
    .live    (sensor_bus),
    .rd_idx  (idx),
    .clr     (peak_clr),
    .rd_peak (peak_val)
  );

  always_comb begin
    case (cmd)
      CMD_READ: lookup_val = live_val;
      CMD_PEAK: lookup_val = peak_val;
      default:  lookup_val = ERR_BYTE;
    endcase
  end

  // Byte 2 on the timeout cycle takes priority over the timeout itself.
  always_comb begin
    state_nxt = state;
    tx_dv     = 1'b0;
    drop_inc  = 1'b0;
    case (state)
      IDLE: begin
        if (rx_dv) begin
          if (rx_byte[7:4] == HDR_NIBBLE) state_nxt = WAIT_B2;
          else                            drop_inc  = 1'b1;
        end
      end
      WAIT_B2: begin
        if (rx_dv) begin
          state_nxt = LOOKUP;
        end else if (gap_cnt == GAP_LAST) begin
          state_nxt = IDLE;
          drop_inc  = 1'b1;
        end
      end
      LOOKUP: begin
        drop_inc  = rx_dv;
        state_nxt = ECHO ? SEND_HDR : SEND_VAL;
      end
      SEND_HDR, SEND_VAL: begin
        drop_inc = rx_dv;
        if (!tx_active) begin
          tx_dv     = 1'b1;
          state_nxt = (state == SEND_HDR) ? WAIT_HDR : WAIT_VAL;
        end
      end
      WAIT_HDR: begin
        drop_inc = rx_dv;
        if (tx_done) state_nxt = SEND_VAL;
      end
      WAIT_VAL: begin
        drop_inc = rx_dv;
        if (tx_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      tx_byte  <= 8'h00;
      drop_cnt <= 8'h00;
      gap_cnt  <= '0;
    end else begin
      state <= state_nxt;
      if (drop_inc && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      if (state == WAIT_B2 && !rx_dv) gap_cnt <= gap_cnt + 1'b1;
      else                            gap_cnt <= '0;
      if (state == LOOKUP)                  tx_byte <= ECHO ? {HDR_NIBBLE, idx} : lookup_val;
      else if (state == WAIT_HDR && tx_done) tx_byte <= val_p1;
    end
  end

  // Request capture and lookup stage (p1) carry no reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && rx_dv && rx_byte[7:4] == HDR_NIBBLE) idx <= rx_byte[3:0];
    if (state == WAIT_B2 && rx_dv) cmd <= rx_byte;
    if (state == LOOKUP) val_p1 <= lookup_val;
  end

endmodule

// File: tb/tb_sensor_node_responder.sv
// Directed and randomized bench for sensor_node_responder with a UART transmitter model.
`timescale 1ns/1ps
module tb_sensor_node_responder;
  import sensor_node_pkg::*;

  localparam int T = 16;
`ifdef SENSOR_NODE_RESP_ECHO_EN
  localparam int NRESP = 2;
`else
  localparam int NRESP = 1;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         rx_dv = 1'b0;
  logic [7:0]   rx_byte = 8'h00;
  logic         tx_active;
  logic         tx_done = 1'b0;
  logic         tx_dv;
  logic [7:0]   tx_byte;
  logic [127:0] sensor_bus = '0;
  logic [7:0]   drop_cnt;

  logic active_reg = 1'b0;
  logic model_busy = 1'b0;
  logic force_busy = 1'b0;
  logic abandon    = 1'b0;
  assign tx_active = active_reg | force_busy;

  int         n_chk = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         len_max = 2;
  int         last_rx_cyc = 0;
  int         exp_drop = 0;
  logic [7:0] cur_byte = 8'h00;
  logic [7:0] tx_q[$];
  int         tx_cyc_q[$];
  logic [7:0] live [16];
  logic [7:0] pk [16];

  sensor_node_responder #(.CLK_FREQ_HZ(25_000_000), .REQ_TIMEOUT_CYCLES(T)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_dv      (rx_dv),
    .rx_byte    (rx_byte),
    .tx_active  (tx_active),
    .tx_done    (tx_done),
    .tx_dv      (tx_dv),
    .tx_byte    (tx_byte),
    .sensor_bus (sensor_bus),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // UART transmitter model: busy for len_max cycles after each start strobe, then tx_done.
  initial begin : tx_model
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk);
      tx_done = 1'b0;
      if (model_busy) begin
        if (cnt == 0) begin
          model_busy = 1'b0;
          tx_done    = 1'b1;
          abandon    = 1'b0;
        end else begin
          cnt--;
        end
      end
      active_reg = model_busy;
      #2;
      if (model_busy && !abandon) chk("tx_byte_hold", tx_byte, cur_byte);
      if (tx_dv === 1'b1) begin
        chk("tx_dv_when_idle", tx_active, 1'b0);
        tx_q.push_back(tx_byte);
        tx_cyc_q.push_back(cyc);
        cur_byte   = tx_byte;
        model_busy = 1'b1;
        cnt        = len_max;
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: time limit reached, %0d checks, %0d failures", n_chk, n_fail);
    $fatal(1, "watchdog expired");
  end

  task automatic note_drop();
    if (exp_drop < 255) exp_drop++;
  endtask

  task automatic send_byte(input logic [7:0] b);
    last_rx_cyc = cyc;
    rx_byte = b;
    rx_dv   = 1'b1;
    @(negedge clk);
    rx_dv   = 1'b0;
  endtask

  task automatic set_sensor(input int i, input logic [7:0] v);
    live[i] = v;
    if (v > pk[i]) pk[i] = v;
    sensor_bus[8*i +: 8] = v;
    @(negedge clk);
  endtask

  task automatic randomize_bus();
    for (int i = 0; i < 16; i++) begin
      live[i] = 8'($urandom);
      if (live[i] > pk[i]) pk[i] = live[i];
      sensor_bus[8*i +: 8] = live[i];
    end
    @(negedge clk);
  endtask

  // Reference: read -> live, peak -> peak since last read (then restart from live), else 0xEE.
  function automatic logic [7:0] ref_value(input logic [3:0] i, input logic [7:0] c);
    logic [7:0] r;
    if (c == 8'h01) begin
      r = live[i];
    end else if (c == 8'h02) begin
      r     = pk[i];
      pk[i] = live[i];
    end else begin
      r = 8'hEE;
    end
    return r;
  endfunction

  task automatic expect_resp(input string tag, input logic [7:0] h, input logic [7:0] v,
                             input int ref_cyc, input int lat);
    int budget;
    budget = 0;
    while ((tx_q.size() < NRESP || model_busy) && budget < 400) begin
      @(negedge clk);
      #3;
      budget++;
    end
    @(negedge clk);
    chk({tag, "_done"}, budget < 400, 1'b1);
    chk({tag, "_count"}, tx_q.size(), NRESP);
    if (tx_q.size() == NRESP) begin
`ifdef SENSOR_NODE_RESP_ECHO_EN
      chk({tag, "_hdr"}, tx_q[0], h);
`endif
      chk({tag, "_val"}, tx_q[NRESP-1], v);
      chk({tag, "_lat"}, tx_cyc_q[0] - ref_cyc, lat);
    end
    tx_q.delete();
    tx_cyc_q.delete();
    chk({tag, "_drop"}, drop_cnt, exp_drop);
  endtask

  task automatic do_request(input string tag, input logic [7:0] h, input logic [7:0] c,
                            input int gap, input int tx_len);
    logic [7:0] v;
    len_max = tx_len;
    send_byte(h);
    repeat (gap - 1) @(negedge clk);
    send_byte(c);
    v = ref_value(h[3:0], c);
    expect_resp(tag, h, v, last_rx_cyc, 2);
  endtask

  initial begin : stim
    logic [7:0] v, h, c, j;
    int req_cyc, rel, nj, b;
    for (int i = 0; i < 16; i++) begin
      live[i] = 8'h00;
      pk[i]   = 8'h00;
    end

    repeat (3) @(negedge clk);
    chk("rst_state", dut.state, IDLE);
    chk("rst_tx_dv", tx_dv, 1'b0);
    chk("rst_tx_byte", tx_byte, 8'h00);
    chk("rst_drop", drop_cnt, 8'h00);
    rst_n = 1'b1;
    @(negedge clk);

    // Header with no second byte times out.
    send_byte(8'h57);
    repeat (T + 2) @(negedge clk);
    note_drop();
    chk("timeout_state", dut.state, IDLE);
    chk("timeout_drop", drop_cnt, 8'h01);
    chk("timeout_no_tx", tx_q.size(), 0);

    set_sensor(6, 8'h3C);
    do_request("read6", 8'h56, 8'h01, 1, 3);

    set_sensor(0, 8'h10);
    set_sensor(0, 8'h80);
    set_sensor(0, 8'h20);
    do_request("peak0_a", 8'h50, 8'h02, 1, 2);
    do_request("peak0_b", 8'h50, 8'h02, 1, 2);

    send_byte(8'hA3);
    note_drop();
    do_request("bad_cmd", 8'h51, 8'h07, 1, 2);

    // Second byte exactly on the last allowed cycle, then one cycle too late.
    do_request("gap_max", 8'h56, 8'h01, T, 1);
    send_byte(8'h52);
    repeat (T) @(negedge clk);
    send_byte(8'h01);
    note_drop();
    note_drop();
    repeat (4) @(negedge clk);
    chk("gap_late_no_tx", tx_q.size(), 0);
    chk("gap_late_drop", drop_cnt, exp_drop);

    // Transmitter busy at lookup, plus a byte landing mid-response.
    len_max = 2;
    set_sensor(13, 8'h9A);
    send_byte(8'h5D);
    force_busy = 1'b1;
    send_byte(8'h02);
    req_cyc = last_rx_cyc;
    v = ref_value(4'hD, 8'h02);
    send_byte(8'h5F);
    note_drop();
    repeat (3) @(negedge clk);
    chk("busy_held", tx_q.size(), 0);
    force_busy = 1'b0;
    rel = cyc;
    expect_resp("busy", 8'h5D, v, rel, 0);
    chk("busy_wait_len", rel - req_cyc, 5);

    for (int k = 0; k < 30; k++) begin
      if ($urandom_range(0, 1) == 1) randomize_bus();
      nj = $urandom_range(0, 2);
      for (int m = 0; m < nj; m++) begin
        j = 8'($urandom);
        if (j[7:4] == 4'h5) j[7:4] = 4'hC;
        send_byte(j);
        note_drop();
      end
      h = {4'h5, 4'($urandom)};
      case ($urandom_range(0, 2))
        0:       c = 8'h01;
        1:       c = 8'h02;
        default: begin
          c = 8'($urandom);
          if (c == 8'h01 || c == 8'h02) c = 8'h80;
        end
      endcase
      do_request($sformatf("rnd%0d", k), h, c, $urandom_range(1, T), $urandom_range(0, 5));
    end

    for (int m = 0; m < 260; m++) begin
      send_byte(8'h00);
      note_drop();
    end
    chk("drop_saturate", drop_cnt, 8'hFF);

    // Reset while the value byte is on the wire.
    len_max = 30;
    send_byte(8'h5A);
    send_byte(8'h01);
    b = 0;
    while (tx_q.size() < NRESP && b < 200) begin
      @(negedge clk);
      #3;
      b++;
    end
    chk("rstmid_reached", b < 200, 1'b1);
    tx_q.delete();
    tx_cyc_q.delete();
    @(negedge clk);
    #3;
    chk("rstmid_state", dut.state, WAIT_VAL);
    abandon = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("rstmid_tx_dv", tx_dv, 1'b0);
    chk("rstmid_tx_byte", tx_byte, 8'h00);
    chk("rstmid_drop", drop_cnt, 8'h00);
    chk("rstmid_idle", dut.state, IDLE);
    exp_drop = 0;
    for (int i = 0; i < 16; i++) pk[i] = live[i];
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("rstmid_silent", tx_q.size(), 0);
    do_request("post_rst", 8'h5A, 8'h02, 1, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
